fnd_scan_controller: RTL

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_pkg.sv | 26 ++
 rtl/fnd_font_rom.sv | 11 +
 rtl/fnd_scan_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the four-digit seven-segment scan controller:
// hex glyphs, digit-enable patterns, slot divider and scan state type.
package fnd_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Active-low gfedcba, index = nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] GLYPH_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low digit enables, index = scan position.
  localparam logic [3:0][3:0] DIGIT_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  localparam logic [7:0] FONT_OFF  = 8'hFF;

  function automatic int fnd_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Combinational hex nibble to active-low seven-segment pattern.
module fnd_font_rom
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TBL[nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed display scanner: per-slot blank window against ghosting,
// frame-aligned data snapshot, leading-zero suppression, registered outputs.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_digitData,
  input  logic [3:0]  i_dpMask,
  input  logic        i_lzs,
  output logic [1:0]  o_digitPosition,
  output logic [3:0]  o_Digit,
  output logic [7:0]  o_font
);

  localparam int DIV = fnd_div(CLK_HZ, SCAN_HZ);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pos_q, pos_d;
  scan_state_e   state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    dp_q, dp_d;
  logic          lzs_q, lzs_d;
  logic          take;
  logic [3:0]    supp;
  logic [3:0]    nib;
  logic [6:0]    seg;
  logic [3:0]    digit_d;
  logic [7:0]    font_d;

  fnd_font_rom u_rom (
    .nibble (nib),
    .seg    (seg)
  );

  always_comb begin
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    state_d = state_q;
    take    = 1'b0;
    if (i_enable) begin
      take = (cnt_q == '0) && (pos_q == 2'd0);
      if (cnt_q == CW'(DIV - 1)) begin
        cnt_d = '0;
        pos_d = pos_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      state_d = (cnt_d < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
    end
  end

  // Glyph is built from the snapshot value being loaded this edge, so a
  // one-cycle blank window still shows fresh frame data.
  always_comb begin
    data_d  = take ? i_digitData : data_q;
    dp_d    = take ? i_dpMask    : dp_q;
    lzs_d   = take ? i_lzs       : lzs_q;
    supp    = 4'b0000;
    supp[3] = (data_d[15:12] == 4'h0);
    supp[2] = supp[3] && (data_d[11:8] == 4'h0);
    supp[1] = supp[2] && (data_d[7:4] == 4'h0);
    nib     = data_d[{pos_d, 2'b00} +: 4];
    digit_d = DIGIT_OFF;
    font_d  = FONT_OFF;
    if (i_enable && state_d == ST_SHOW) begin
      digit_d = DIGIT_EN[pos_d];
      if (!(lzs_d && supp[pos_d]))
        font_d = {~dp_d[pos_d], seg};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      pos_q   <= 2'd0;
      state_q <= ST_BLANK;
      data_q  <= 16'h0000;
      dp_q    <= 4'h0;
      lzs_q   <= 1'b0;
      o_Digit <= DIGIT_OFF;
      o_font  <= FONT_OFF;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      state_q <= state_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      lzs_q   <= lzs_d;
      o_Digit <= digit_d;
      o_font  <= font_d;
    end
  end

  assign o_digitPosition = pos_q;

endmodule
